// File: rtl/md_sequencer_if.sv
// Decode-side handshake and HI/LO result bundle for the multiply/divide sequencer.
interface md_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             rd_req;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, opA, opB, rd_req,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, opA, opB, rd_req,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/md_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit sharing one shift-add / restoring-divide datapath.
//   state | meaning
//   IDLE  | waiting for start, hi/lo hold last result
//   CALC  | one datapath iteration per cycle, WIDTH cycles
//   FIX   | sign correction and hi/lo write-back
module md_sequencer #(
  parameter int WIDTH = 32
) (
  input logic        clock,
  input logic        resetn,
  md_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               signed_op;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign signed_op = ~bus.op[0];
  assign abs_a = (signed_op && bus.opA[WIDTH-1]) ? -bus.opA : bus.opA;
  assign abs_b = (signed_op && bus.opB[WIDTH-1]) ? -bus.opB : bus.opB;

  // acc holds {upper, multiplier} for multiply and {remainder, quotient} for divide
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
  assign div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};

  always_comb begin
    acc_next = acc;
    if (is_div) begin
      if (!div_diff[WIDTH])
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {(acc[0] ? mul_sum : {1'b0, acc[2*WIDTH-1:WIDTH]}), acc[WIDTH-1:1]};
    end
  end

  // A zero divisor leaves quotient all-ones and remainder |opA|, never negated
  assign prod_fix = neg_res ? -acc : acc;
  assign quot_fix = (neg_res && !div_zero) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = (neg_rem && !div_zero) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      operand  <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            is_div   <= bus.op[1];
            neg_res  <= signed_op & (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
            neg_rem  <= signed_op & bus.opA[WIDTH-1];
            div_zero <= (bus.opB == '0);
            cnt      <= '0;
            busy_q   <= 1'b1;
            state    <= CALC;
            if (bus.op[1]) begin
              acc     <= {{WIDTH{1'b0}}, abs_a};
              operand <= abs_b;
            end else begin
              acc     <= {{WIDTH{1'b0}}, abs_b};
              operand <= abs_a;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST)
            state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.stall = busy_q & (bus.start | bus.rd_req);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
endmodule

// File: tb/tb_md_sequencer.sv
// Directed and random MULT/DIV runs against a 64-bit arithmetic reference model.
module tb_md_sequencer;
  logic clock;
  logic resetn;
  int   tests;
  int   fails;
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  md_sequencer_if #(.WIDTH(32)) bus ();

  md_sequencer #(.WIDTH(32)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {hi, lo} from plain integer arithmetic; / and % truncate toward zero like MIPS
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] ua;
    logic [63:0] ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'd0) return {(a[31] ? -a : a), 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int rd_at, input int st_at);
    logic [63:0] exp;
    int   cyc;
    logic seq_ok;
    logic stall_ok;
    exp = ref_model(o, a, b);
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = o;
    bus.opA   = a;
    bus.opB   = b;
    @(negedge clock);
    bus.start = 1'b0;
    check("busy_after_accept", 64'(bus.busy), 64'd1);
    cyc = 0;
    seq_ok = 1'b1;
    stall_ok = 1'b1;
    while (bus.busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (cyc == rd_at) bus.rd_req = 1'b1;
      if (cyc == st_at) begin
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.opA   = 32'd9;
        bus.opB   = 32'd9;
      end
      if (cyc == st_at + 3) bus.start = 1'b0;
      #1;
      if (bus.stall !== (bus.start | bus.rd_req)) stall_ok = 1'b0;
      if (bus.hi !== last_hi || bus.lo !== last_lo || bus.done !== 1'b0) seq_ok = 1'b0;
      @(negedge clock);
    end
    check("busy_cycles", 64'(cyc), 64'd33);
    check("hold_while_busy", 64'(seq_ok), 64'd1);
    check("stall_while_busy", 64'(stall_ok), 64'd1);
    check("done_first_idle", 64'(bus.done), 64'd1);
    check("stall_first_idle", 64'(bus.stall), 64'd0);
    check("hi", 64'(bus.hi), 64'(exp[63:32]));
    check("lo", 64'(bus.lo), 64'(exp[31:0]));
    last_hi = exp[63:32];
    last_lo = exp[31:0];
    bus.rd_req = 1'b0;
    @(negedge clock);
    check("done_pulse_width", 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [31:0] specials [6];
    logic [31:0] ra;
    logic [31:0] rb;
    tests = 0;
    fails = 0;
    last_hi = '0;
    last_lo = '0;
    specials[0] = 32'd0;
    specials[1] = 32'd1;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000;
    specials[4] = 32'h7FFF_FFFF;
    specials[5] = 32'd2;
    resetn = 1'b0;
    bus.start = 1'b1;
    bus.op = 2'b00;
    bus.opA = 32'd3;
    bus.opB = 32'd4;
    bus.rd_req = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    bus.start = 1'b0;
    bus.rd_req = 1'b0;
    resetn = 1'b1;

    // reset in the middle of CALC discards the operation
    @(negedge clock);
    bus.start = 1'b1;
    bus.op = 2'b00;
    bus.opA = 32'd7;
    bus.opB = 32'd6;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (9) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    resetn = 1'b1;
    last_hi = '0;
    last_lo = '0;
    do_op(2'b00, 32'd2, 32'd3, -1, -1);

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, -1, -1);
    do_op(2'b11, 32'd100, 32'd7, -1, -1);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, -1);
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, -1, -1);
    do_op(2'b11, 32'd5, 32'd0, -1, -1);
    do_op(2'b10, 32'hFFFF_FFFB, 32'd0, -1, -1);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, -1, -1);
    do_op(2'b00, 32'd7, 32'd6, 5, -1);
    do_op(2'b00, 32'd7, 32'd6, -1, 8);
    do_op(2'b01, 32'd11, 32'd13, -1, -1);

    for (int i = 0; i < 12; i++) begin
      ra = $urandom();
      rb = $urandom();
      if ($urandom_range(0, 3) == 0) ra = specials[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) rb = specials[$urandom_range(0, 5)];
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(8, 31);
      do_op(2'($urandom_range(0, 3)), ra, rb, int'($urandom_range(0, 40)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
